// File: rtl/updown_sweep_ctrl.sv
// Sequencer that drives a 7-bit up/down counter through a triangle sweep
// between latched low/high bounds, with programmable dwell at each bound.
module updown_sweep_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [6:0]         lo_bound,
  input  logic [6:0]         hi_bound,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         sweeps,
  input  logic [6:0]         cnt_value,
  output logic               cnt_enable,
  output logic               cnt_direction,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [7:0]         sweep_count,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RISE    = 3'd1,
    S_HOLD_HI = 3'd2,
    S_FALL    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [6:0]           lo_q, lo_d;
  logic [6:0]           hi_q, hi_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [7:0]           sweeps_q, sweeps_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [7:0]           sweep_count_q, sweep_count_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      dwell_q       <= '0;
      sweeps_q      <= '0;
      dwell_cnt_q   <= '0;
      sweep_count_q <= '0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      dwell_q       <= dwell_d;
      sweeps_q      <= sweeps_d;
      dwell_cnt_q   <= dwell_cnt_d;
      sweep_count_q <= sweep_count_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  // Handshake: start is a level sampled only in IDLE (no ready; busy=0 means
  // it will be taken); abort is a level that overrides everything when busy.
  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    dwell_d       = dwell_q;
    sweeps_d      = sweeps_q;
    dwell_cnt_d   = dwell_cnt_q;
    sweep_count_d = sweep_count_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    cnt_enable    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (lo_bound >= hi_bound) begin
            cfg_err_d = 1'b1;
          end else begin
            lo_d          = lo_bound;
            hi_d          = hi_bound;
            dwell_d       = dwell;
            sweeps_d      = sweeps;
            sweep_count_d = '0;
            state_d       = S_RISE;
          end
        end
      end
      S_RISE: begin
        // Comparing the live counter value stops it exactly at hi, and a
        // counter already past hi turns around instead of wrapping.
        cnt_enable = (cnt_value < hi_q);
        if (cnt_value >= hi_q) begin
          state_d     = S_HOLD_HI;
          dwell_cnt_d = dwell_q;
        end
      end
      S_HOLD_HI, S_HOLD_LO: begin
        if (dwell_cnt_q == '0) begin
          state_d = (state_q == S_HOLD_HI) ? S_FALL : S_RISE;
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      S_FALL: begin
        cnt_enable = (cnt_value > lo_q);
        if (cnt_value <= lo_q) begin
          sweep_count_d = sweep_count_q + 8'd1;
          if ((sweeps_q != 8'd0) && (sweep_count_q + 8'd1 == sweeps_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d     = S_HOLD_LO;
            dwell_cnt_d = dwell_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      cnt_enable    = 1'b0;
      state_d       = S_IDLE;
      done_d        = 1'b0;
      sweep_count_d = sweep_count_q;
      dwell_cnt_d   = dwell_cnt_q;
    end
  end

  assign cnt_direction = (state_q == S_IDLE) || (state_q == S_RISE) ||
                         (state_q == S_HOLD_LO);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign sweep_count   = sweep_count_q;
  assign state_dbg     = state_q;

endmodule
